// File: rtl/decimal_to_bin_pkg.sv
// Shared widths and FSM encodings for the two-digit BCD to binary converter.
package decimal_to_bin_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_W       = 2 * BCD_DIGIT_W;
  localparam int BIN_W       = 7;
  localparam int N_SHIFTS    = 7;
  localparam int ITER_W      = 3;

  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_ADJUST = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    ADJUST = ST_ADJUST,
    DONE   = ST_DONE
  } state_e;

endpackage

// File: rtl/decimal_to_bin_if.sv
// Request/result bundle between the digit-entry logic and the converter.
interface decimal_to_bin_if;
  import decimal_to_bin_pkg::*;

  logic                   start_i;
  logic [BCD_DIGIT_W-1:0] tens_i;
  logic [BCD_DIGIT_W-1:0] ones_i;
  logic                   busy_o;
  logic                   done_o;
  logic [BIN_W-1:0]       bin_o;
  logic                   err_o;

  modport master (
    output start_i, tens_i, ones_i,
    input  busy_o, done_o, bin_o, err_o
  );

  modport slave (
    input  start_i, tens_i, ones_i,
    output busy_o, done_o, bin_o, err_o
  );

endinterface

// File: rtl/decimal_to_bin_digit_adjust.sv
// One reverse double-dabble correction step for a single BCD nibble.
module bcd_digit_adjust
  import decimal_to_bin_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] nibble_i,
  output logic [BCD_DIGIT_W-1:0] nibble_o
);

  assign nibble_o = (nibble_i >= BCD_DIGIT_W'(8)) ? nibble_i - BCD_DIGIT_W'(3) : nibble_i;

endmodule

// File: rtl/decimal_to_bin.sv
// Sequential two-digit BCD to 7-bit binary converter (shift-right / subtract-3),
// fixed 14-cycle latency from an accepted start to the done pulse.
module decimal_to_bin
  import decimal_to_bin_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  decimal_to_bin_if.slave bus
);

  state_e              state_q, state_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic                err_q, err_d;
  logic [BIN_W-1:0]    bin_out_q, bin_out_d;
  logic                err_out_q, err_out_d;
  logic                done_q, done_d;
  logic [BCD_DIGIT_W-1:0] adj_hi, adj_lo;

  bcd_digit_adjust u_adj_tens (
    .nibble_i (bcd_q[BCD_W-1:BCD_DIGIT_W]),
    .nibble_o (adj_hi)
  );

  bcd_digit_adjust u_adj_ones (
    .nibble_i (bcd_q[BCD_DIGIT_W-1:0]),
    .nibble_o (adj_lo)
  );

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    iter_d    = iter_q;
    err_d     = err_q;
    bin_out_d = bin_out_q;
    err_out_d = err_out_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          bcd_d   = {bus.tens_i, bus.ones_i};
          bin_d   = '0;
          iter_d  = '0;
          err_d   = (bus.tens_i > BCD_MAX) | (bus.ones_i > BCD_MAX);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // bcd_q[0] migrates into the top of the binary accumulator.
        bcd_d   = {1'b0, bcd_q[BCD_W-1:1]};
        bin_d   = {bcd_q[0], bin_q[BIN_W-1:1]};
        iter_d  = iter_q + ITER_W'(1);
        state_d = (iter_d == ITER_W'(N_SHIFTS)) ? DONE : ADJUST;
      end
      ADJUST: begin
        bcd_d   = {adj_hi, adj_lo};
        state_d = SHIFT;
      end
      DONE: begin
        bin_out_d = err_q ? '0 : bin_q;
        err_out_d = err_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      iter_q    <= '0;
      err_q     <= 1'b0;
      bin_out_q <= '0;
      err_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      iter_q    <= iter_d;
      err_q     <= err_d;
      bin_out_q <= bin_out_d;
      err_out_q <= err_out_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy_o = (state_q != IDLE);
  assign bus.done_o = done_q;
  assign bus.bin_o  = bin_out_q;
  assign bus.err_o  = err_out_q;

endmodule

// File: tb/tb_decimal_to_bin.sv
// Scoreboard bench for decimal_to_bin: stimulus queues expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_decimal_to_bin;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  typedef struct {
    logic [6:0] bin;
    logic       err;
    logic [3:0] tens;
    logic [3:0] ones;
    int         due;
  } exp_t;

  exp_t sb_q[$];
  int   busy_run = 0;

  decimal_to_bin_if bus ();

  decimal_to_bin dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d cycles required completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("done_latency", cyc, e.due);
        check("bin_o", {25'd0, bus.bin_o}, {25'd0, e.bin});
        check("err_o", {31'd0, bus.err_o}, {31'd0, e.err});
        check("busy_len", busy_run, 14);
        if (!e.err)
          check("round_trip", (bus.bin_o / 10) * 16 + (bus.bin_o % 10),
                {24'd0, e.tens, e.ones});
      end
    end
    if (bus.busy_o === 1'b1) busy_run++;
    else busy_run = 0;
  end

  task automatic push(input logic [6:0] b, input logic e, input logic [3:0] t,
                      input logic [3:0] o, input int due);
    exp_t x;
    x.bin = b; x.err = e; x.tens = t; x.ones = o; x.due = due;
    sb_q.push_back(x);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy_o !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic convert(input logic [3:0] t, input logic [3:0] o,
                         input logic [6:0] eb, input logic ee);
    wait_idle();
    bus.start_i = 1'b1;
    bus.tens_i  = t;
    bus.ones_i  = o;
    @(posedge clk);
    #1;
    push(eb, ee, t, o, cyc + 14);
    bus.start_i = 1'b0;
  endtask

  initial begin
    int wait_n;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.tens_i  = 4'd0;
    bus.ones_i  = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("rst_done", {31'd0, bus.done_o}, 32'd0);
    check("rst_bin",  {25'd0, bus.bin_o},  32'd0);
    check("rst_err",  {31'd0, bus.err_o},  32'd0);
    rst = 1'b0;

    convert(4'd9, 4'd9, 7'd99, 1'b0);
    convert(4'd4, 4'd2, 7'd42, 1'b0);
    convert(4'd0, 4'd0, 7'd0,  1'b0);
    convert(4'd1, 4'd9, 7'd19, 1'b0);
    convert(4'd8, 4'd0, 7'd80, 1'b0);

    for (int t = 0; t < 10; t++)
      for (int o = 0; o < 10; o++)
        convert(4'(t), 4'(o), 7'(t * 10 + o), 1'b0);

    // Invalid digits: forced zero with error, then cleared by a valid one.
    convert(4'hA, 4'd3, 7'd0,  1'b1);
    convert(4'd2, 4'd1, 7'd21, 1'b0);
    convert(4'd5, 4'hF, 7'd0,  1'b1);
    convert(4'd6, 4'd7, 7'd67, 1'b0);

    // Start while busy is ignored.
    convert(4'd0, 4'd5, 7'd5, 1'b0);
    repeat (4) @(posedge clk);
    bus.start_i = 1'b1;
    bus.tens_i  = 4'd7;
    bus.ones_i  = 4'd7;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;

    // Reset at E5 aborts: no done, outputs back to reset values.
    convert(4'd3, 4'd4, 7'd34, 1'b0);
    void'(sb_q.pop_back());
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", {31'd0, bus.busy_o}, 32'd0);
    check("abort_done", {31'd0, bus.done_o}, 32'd0);
    check("abort_bin",  {25'd0, bus.bin_o},  32'd0);
    check("abort_err",  {31'd0, bus.err_o},  32'd0);
    bus.start_i = 1'b0;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    convert(4'd3, 4'd4, 7'd34, 1'b0);

    // start_i held high: one conversion every 15 cycles.
    wait_idle();
    bus.start_i = 1'b1;
    bus.tens_i  = 4'd1;
    bus.ones_i  = 4'd2;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      push(7'd12, 1'b0, 4'd1, 4'd2, cyc + 14);
      if (k < 2) repeat (14) @(posedge clk);
    end
    bus.start_i = 1'b0;

    wait_n = 0;
    while (sb_q.size() > 0 && wait_n < 60) begin
      @(posedge clk);
      wait_n++;
    end
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("missing_done", 32'd0, {25'd0, e.bin});
      if (e.bin == 7'd0) check("missing_done_zero", 32'd0, 32'd1);
    end
    repeat (20) @(posedge clk);
    #1;
    check("final_idle", {31'd0, bus.busy_o}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
